// File: rtl/tdm_codec_if_if.sv
// Bundle of the codec serial pins and calibrator-side sample buses for tdm_codec_if.
// The DUT takes the slave view; a codec/calibrator model takes the master view.
interface tdm_codec_if_if #(
    parameter int W = 16
);
    logic                mute;
    logic signed [W-1:0] sample_out0;
    logic signed [W-1:0] sample_out1;
    logic signed [W-1:0] sample_out2;
    logic signed [W-1:0] sample_out3;
    logic                sdin;
    logic                bick;
    logic                lrck;
    logic                sdout;
    logic                clk_fs;
    logic signed [W-1:0] sample_in0;
    logic signed [W-1:0] sample_in1;
    logic signed [W-1:0] sample_in2;
    logic signed [W-1:0] sample_in3;

    modport slave (
        input  mute, sample_out0, sample_out1, sample_out2, sample_out3, sdin,
        output bick, lrck, sdout, clk_fs, sample_in0, sample_in1, sample_in2, sample_in3
    );

    modport master (
        output mute, sample_out0, sample_out1, sample_out2, sample_out3, sdin,
        input  bick, lrck, sdout, clk_fs, sample_in0, sample_in1, sample_in2, sample_in3
    );
endinterface

// File: rtl/tdm_codec_if.sv
// 4-slot TDM front end: BICK/LRCK/clk_fs generation, DAC serialiser, ADC deserialiser.
// Define TDM_LOOPBACK_EN to feed the ADC shift registers from the internal sdout stream.
module tdm_codec_if #(
    parameter int W = 16
) (
    input  logic          clk_256fs,
    input  logic          rst,
    tdm_codec_if_if.slave bus
);
    logic [7:0]   cnt;
    logic [7:0]   cnt_next;
    logic         run;
    logic         bick_q;
    logic         lrck_q;
    logic         clk_fs_q;
    logic         sdout_q;
    logic         sdout_next;
    logic         adc_bit;
    logic         latch_en;
    logic         publish_en;
    logic [1:0]   slot_cur;
    logic [4:0]   bit_cur;
    logic [W-1:0] sample_out [4];
    logic [W-1:0] holding [4];
    logic [W-1:0] holding_next [4];
    logic [W-1:0] shreg [4];
    logic [W-1:0] shreg_next [4];
    logic [W-1:0] sample_in_q [4];
    logic [W-1:0] dac_word;

    assign sample_out[0] = bus.sample_out0;
    assign sample_out[1] = bus.sample_out1;
    assign sample_out[2] = bus.sample_out2;
    assign sample_out[3] = bus.sample_out3;

`ifdef TDM_LOOPBACK_EN
    logic unused_sdin;
    assign unused_sdin = bus.sdin;
    assign adc_bit     = sdout_q;
`else
    assign adc_bit     = bus.sdin;
`endif

    // The first cycle after reset release sits at cnt == 0, so the counter
    // only starts advancing once run is set.
    assign cnt_next   = run ? cnt + 8'd1 : 8'd0;
    assign latch_en   = (cnt_next == 8'd0);
    assign publish_en = run && (cnt == 8'hFF);
    assign slot_cur   = cnt[7:6];
    assign bit_cur    = cnt[5:1];

    // NOTE: every variable written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        for (int s = 0; s < 4; s++) begin
            holding_next[s] = holding[s];
            shreg_next[s]   = shreg[s];
            if (latch_en) begin
                holding_next[s] = bus.mute ? '0 : sample_out[s];
            end
        end
        if (cnt[0] && (int'(bit_cur) < W)) begin
            shreg_next[slot_cur] = {shreg[slot_cur][W-2:0], adc_bit};
        end
        // Left-shifting by the bit index brings that bit to the MSB; indices >= W shift out to 0.
        dac_word   = holding_next[cnt_next[7:6]] << cnt_next[5:1];
        sdout_next = dac_word[W-1];
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk_256fs) begin
        if (rst) begin
            run      <= 1'b0;
            cnt      <= 8'd0;
            bick_q   <= 1'b0;
            lrck_q   <= 1'b0;
            clk_fs_q <= 1'b0;
            sdout_q  <= 1'b0;
            // NOTE: these arrays are reset explicitly because their contents are visible on outputs after release.
            for (int s = 0; s < 4; s++) begin
                holding[s]     <= '0;
                shreg[s]       <= '0;
                sample_in_q[s] <= '0;
            end
        end else begin
            run      <= 1'b1;
            cnt      <= cnt_next;
            bick_q   <= cnt_next[0];
            lrck_q   <= ~cnt_next[7];
            clk_fs_q <= ~cnt_next[7];
            sdout_q  <= sdout_next;
            for (int s = 0; s < 4; s++) begin
                holding[s] <= holding_next[s];
                shreg[s]   <= shreg_next[s];
                if (publish_en) begin
                    sample_in_q[s] <= shreg_next[s];
                end
            end
        end
    end

    assign bus.bick       = bick_q;
    assign bus.lrck       = lrck_q;
    assign bus.clk_fs     = clk_fs_q;
    assign bus.sdout      = sdout_q;
    assign bus.sample_in0 = sample_in_q[0];
    assign bus.sample_in1 = sample_in_q[1];
    assign bus.sample_in2 = sample_in_q[2];
    assign bus.sample_in3 = sample_in_q[3];
endmodule

// File: tb/tb_tdm_codec_if.sv
// Randomised self-checking bench for tdm_codec_if: a frame-level model builds the
// expected 256-cycle serial streams and published samples; one process compares every cycle.
module tb_tdm_codec_if;
    localparam int W = 16;

`ifdef TDM_LOOPBACK_EN
    localparam bit LOOPBACK = 1'b1;
    localparam logic [W-1:0] SO_DIR [4] = '{16'h0F0F, 16'hF0F0, 16'h8000, 16'h0000};
    localparam logic [W-1:0] IN_LIT [4] = '{16'h0F0F, 16'hF0F0, 16'h8000, 16'h0000};
    localparam logic         SDOUT0_LIT = 1'b0;
`else
    localparam bit LOOPBACK = 1'b0;
    localparam logic [W-1:0] SO_DIR [4] = '{16'h8001, 16'h7FFF, 16'h1234, 16'hFFFF};
    localparam logic [W-1:0] IN_LIT [4] = '{16'hA5A5, 16'h0001, 16'hC000, 16'h7FFE};
    localparam logic         SDOUT0_LIT = 1'b1;
`endif
    localparam logic [W-1:0] ADC_DIR [4] = '{16'hA5A5, 16'h0001, 16'hC000, 16'h7FFE};

    logic clk_256fs = 1'b0;
    logic rst = 1'b1;

    tdm_codec_if_if #(.W(W)) bus ();
    tdm_codec_if #(.W(W)) dut (
        .clk_256fs (clk_256fs),
        .rst       (rst),
        .bus       (bus.slave)
    );

    always #5 clk_256fs = ~clk_256fs;

    logic [W-1:0] so [4];
    logic         mute_v = 1'b0;
    logic         sdin_v = 1'b0;

    assign bus.sample_out0 = so[0];
    assign bus.sample_out1 = so[1];
    assign bus.sample_out2 = so[2];
    assign bus.sample_out3 = so[3];
    assign bus.mute        = mute_v;
    assign bus.sdin        = sdin_v;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %h expected %h at time %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model state
    bit           model_valid = 1'b0;
    bit           m_rst = 1'b1;
    logic [7:0]   pos = 8'd0;
    logic [W-1:0] latched [4];
    logic [W-1:0] adc_word [4];
    logic [W-1:0] exp_in [4];
    logic [255:0] dac_stream = '0;
    logic [255:0] adc_stream = '0;
    int           frame_no = 0;
    int           ones = 0;
    int           prev_ones = 0;

    // A slot carries its word MSB-first in bits 0..W-1, each bit lasting two cycles.
    function automatic logic [255:0] to_stream(input logic [W-1:0] w [4], input logic [31:0] fill [4]);
        logic [255:0] st;
        logic [31:0]  sw;
        logic [7:0]   idx;
        st = '0;
        for (int s = 0; s < 4; s++) begin
            sw = (32'(w[s]) << (32 - W)) | (fill[s] >> W);
            for (int k = 0; k < 32; k++) begin
                idx            = 8'(s * 64 + 2 * k);
                st[idx]        = sw[5'(31 - k)];
                st[idx + 8'd1] = sw[5'(31 - k)];
            end
        end
        return st;
    endfunction

    task automatic step();
        logic         r;
        logic         mv;
        logic [W-1:0] soc [4];
        logic [31:0]  fill [4];
        logic [31:0]  nofill [4];
        r   = rst;
        mv  = mute_v;
        soc = so;
        @(posedge clk_256fs);
        #1;
        if (r) begin
            model_valid = 1'b1;
            m_rst = 1'b1;
            for (int s = 0; s < 4; s++) exp_in[s] = '0;
        end else begin
            pos = m_rst ? 8'd0 : pos + 8'd1;
            if (pos == 8'd0) begin
                if (!m_rst) begin
                    for (int s = 0; s < 4; s++) exp_in[s] = LOOPBACK ? latched[s] : adc_word[s];
                    prev_ones = ones;
                end
                for (int s = 0; s < 4; s++) begin
                    latched[s]  = mv ? '0 : soc[s];
                    adc_word[s] = (frame_no == 0) ? ADC_DIR[s] : W'($urandom);
                    fill[s]     = $urandom;
                    nofill[s]   = '0;
                end
                dac_stream = to_stream(latched, nofill);
                adc_stream = to_stream(adc_word, fill);
                frame_no++;
                ones = 0;
            end
            m_rst = 1'b0;
        end
        if (!m_rst) ones += int'(bus.sdout);
        sdin_v = m_rst ? 1'($urandom) : adc_stream[pos];
    endtask

    task automatic run_to(input logic [7:0] p);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while ((m_rst || pos != p) && n < 600);
        if (n >= 600) begin
            failures++;
            $display("FAIL run_to: position %0d not reached within 600 cycles", p);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk_256fs) begin
        if (model_valid) begin
            logic eb, el, es;
            eb = m_rst ? 1'b0 : pos[0];
            el = m_rst ? 1'b0 : ~pos[7];
            es = m_rst ? 1'b0 : dac_stream[pos];
            check("bick", 32'(bus.bick), 32'(eb));
            check("lrck", 32'(bus.lrck), 32'(el));
            check("clk_fs", 32'(bus.clk_fs), 32'(el));
            check("sdout", 32'(bus.sdout), 32'(es));
            check("sample_in0", 32'($unsigned(bus.sample_in0)), 32'(exp_in[0]));
            check("sample_in1", 32'($unsigned(bus.sample_in1)), 32'(exp_in[1]));
            check("sample_in2", 32'($unsigned(bus.sample_in2)), 32'(exp_in[2]));
            check("sample_in3", 32'($unsigned(bus.sample_in3)), 32'(exp_in[3]));
        end
    end

    initial begin
        so = SO_DIR;
        repeat (4) step();
        check("reset_lrck", 32'(bus.lrck), 32'd0);
        check("reset_sdout", 32'(bus.sdout), 32'd0);
        check("reset_sample_in0", 32'($unsigned(bus.sample_in0)), 32'd0);

        rst = 1'b0;
        step();
        check("release_lrck", 32'(bus.lrck), 32'd1);
        check("release_clk_fs", 32'(bus.clk_fs), 32'd1);
        check("release_bick", 32'(bus.bick), 32'd0);
        check("release_sdout", 32'(bus.sdout), 32'(SDOUT0_LIT));

        run_to(8'd0);
        check("frame1_in0", 32'($unsigned(bus.sample_in0)), 32'(IN_LIT[0]));
        check("frame1_in1", 32'($unsigned(bus.sample_in1)), 32'(IN_LIT[1]));
        check("frame1_in2", 32'($unsigned(bus.sample_in2)), 32'(IN_LIT[2]));
        check("frame1_in3", 32'($unsigned(bus.sample_in3)), 32'(IN_LIT[3]));

        // Mid-frame sample_out changes must only take effect at the next frame
        repeat (4) begin
            run_to(8'(20 + $urandom_range(0, 180)));
            for (int s = 0; s < 4; s++) so[s] = W'($urandom);
            run_to(8'd0);
        end

        // Mute sampled only at frame start
        run_to(8'd50);
        so = SO_DIR;
        run_to(8'd100);
        mute_v = 1'b1;
        run_to(8'd0);
        run_to(8'd10);
        mute_v = 1'b0;
        run_to(8'd0);
        check("muted_frame_ones", 32'(prev_ones), 32'd0);
        run_to(8'd0);
        check("unmuted_frame_has_data", 32'(prev_ones != 0), 32'd1);

        // Reset pulse mid-frame discards the partial frame
        run_to(8'd150);
        rst = 1'b1;
        repeat (3) step();
        check("pulse_bick", 32'(bus.bick), 32'd0);
        check("pulse_sample_in0", 32'($unsigned(bus.sample_in0)), 32'd0);
        rst = 1'b0;
        step();
        run_to(8'd255);
        check("post_reset_in0_held", 32'($unsigned(bus.sample_in0)), 32'd0);
        check("post_reset_in3_held", 32'($unsigned(bus.sample_in3)), 32'd0);
        run_to(8'd0);

        repeat (2) begin
            run_to(8'(20 + $urandom_range(0, 180)));
            for (int s = 0; s < 4; s++) so[s] = W'($urandom);
            run_to(8'd0);
        end
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tdm_codec_if.md
Name: tdm_codec_if

Overview:
- Serial front end between the 4-in/4-out audio codec's TDM port and the calibrator.
- Runs on clk_256fs. Generates the BICK, LRCK and clk_fs timing.
- Deserialises 4 raw ADC slots onto parallel sample_in0..3, which feed the calibrator's in0..in3.
- Serialises calibrated DAC samples sample_out0..3 (the calibrator's out4..out7) onto sdout.

Parameters:
- W, 16: sample width. Legal range 8..32. Samples sit MSB-first at the start of each 32-bit slot.

Ports:
- clk_256fs  in  1  system clock, 256 x fs; also forwarded to the codec as MCLK
- rst  in  1  synchronous, active-high reset
- mute  in  1  when high, DAC slots transmit zero
- sample_out0..sample_out3  in  W each  signed DAC samples for slots 0..3
- sdin  in  1  codec ADC serial data (codec SDTO)
- bick  out  1  bit clock, 128 x fs
- lrck  out  1  frame clock, fs, 50% duty
- sdout  out  1  DAC serial data (codec SDTI)
- clk_fs  out  1  sample-rate strobe to downstream blocks
- sample_in0..sample_in3  out  W each  signed raw ADC samples for slots 0..3

Behaviour:
- Counter cnt, 8 bits:
  - Increments every clk_256fs; wraps 255 -> 0. Held at 0 while rst.
  - slot = cnt[7:6]; bit = cnt[5:1], values 0..31.
- Timing outputs are registered and always equal these functions of the current cnt:
  - bick = cnt[0]
  - lrck = ~cnt[7]
  - clk_fs = ~cnt[7]
  - All three are 0 while rst is asserted.
- After rst deasserts:
  - cnt = 0 in the first cycle; bick = 0, lrck = 1, clk_fs = 1.
  - clk_fs therefore rises at the start of every frame.
- DAC path:
  - In the cycle where cnt == 0, copy sample_out0..3 into a 4 x W holding register.
  - If mute is 1 at that edge, store zeros instead. mute is sampled only at frame start.
  - sdout for (slot s, bit b) is driven from the cycle where cnt == {s, b, 1'b0}, i.e. at bick falling.
  - It holds for 2 cycles: holding[s][W-1-b] for b < W, otherwise 0.
  - A change to sample_out mid-frame has no effect until the next frame.
- ADC path:
  - sdin is sampled at the clk_256fs edge that ends each cycle with cnt[0] == 1 (bick high).
  - Bit b < W of slot s is shifted MSB-first into that slot's shift register.
  - Bits b >= W are ignored.
- Publish:
  - At the edge where cnt wraps 255 -> 0, all four shift registers transfer to sample_in0..3 simultaneously.
  - New values appear in the same cycle clk_fs rises.
  - Latency from the first ADC bit of slot 0 to sample_in0 update is 256 cycles.
  - sample_in is stable for the full 256-cycle frame.
- Arithmetic: no arithmetic; two's-complement bits are passed through unchanged.
- Reset values: sdout = 0; sample_in0..3 = 0; holding register = 0; shift registers = 0.
- Reset mid-frame:
  - The partial frame is discarded; sample_in keeps 0.
  - The first valid sample_in is published at the end of the first complete frame after release.
- Simultaneous events: rst has priority over publish, latch and counter increment.

Optional Feature:
- Macro TDM_LOOPBACK_EN.
- When defined:
  - sdin is ignored.
  - The ADC shift registers load from the internal sdout bit stream, sampled at the same instants.
  - sample_inN at frame k+1 equals the sample_outN value latched at the start of frame k, or 0 if muted.
- When undefined: normal sdin path; no loopback logic is present.

Test Plan:
- Reset release -> cnt and sample_in0..3 are 0; bick toggles every cycle. lrck and clk_fs are 1 for 128 cycles, then 0 for 128, repeating with period 256.
- sample_out0..3 = 0x8001, 0x7FFF, 0x1234, 0xFFFF held from frame start -> sdout slot bits 0..15 match MSB-first, bits 16..31 are 0. Each bit changes only at bick falling edges.
- Codec model drives 0xA5A5, 0x0001, 0xC000, 0x7FFE MSB-first on sdin, changing on bick falling -> sample_in0..3 equal those values when clk_fs next rises and stay constant for 256 cycles.
- mute = 1 asserted at cnt == 100, released at cnt == 10 of the next frame -> the current frame transmits its latched data unchanged; the next frame transmits all zeros; the frame after transmits data again.
- rst pulsed for 3 cycles at cnt == 150 -> all outputs 0 during reset; sample_in stays 0 for the next full frame, then updates with valid data.
- With TDM_LOOPBACK_EN, sample_out = 0x0F0F, 0xF0F0, 0x8000, 0x0000 -> sample_in matches one frame later.
